// File: rtl/i2s_rx_pkg.sv
// Shared definitions for the I2S receive path.
//   state_e : receiver protocol states (SYNC / SHIFT / DONE)
//   chan_e  : channel code carried on ADCLRC (LEFT = 0, RIGHT = 1)
//   I2S_DELAY_BITS : bit clocks between a word-select change and the MSB
package i2s_rx_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } chan_e;

  localparam int unsigned I2S_DELAY_BITS = 1;

endpackage

// File: rtl/i2s_edge_sync.sv
// Brings the asynchronous I2S lines into the clk domain.
//   clk, reset   : system clock, synchronous active-high reset
//   sclk         : bit clock, 3-stage synchroniser for rise detection
//   lrclk, sdata : word select and data, 2-stage synchronisers
//   sclk_rise    : one-clk pulse per detected BCLK rising edge
//   lrclk_s      : synchronised word select, aligned with sclk_rise
//   sdata_s      : synchronised data, aligned with sclk_rise
module i2s_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic lrclk,
  input  logic sdata,
  output logic sclk_rise,
  output logic lrclk_s,
  output logic sdata_s
);

  logic [2:0] sclk_q;
  logic [1:0] lrclk_q;
  logic [1:0] sdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q  <= '0;
      lrclk_q <= '0;
      sdata_q <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      lrclk_q <= {lrclk_q[0], lrclk};
      sdata_q <= {sdata_q[0], sdata};
    end
  end

  // Stage 2 of every line has the same latency, so the data seen with the
  // rise pulse is the value that was on the pins at the BCLK edge.
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign lrclk_s   = lrclk_q[1];
  assign sdata_s   = sdata_q[1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises the codec ADC stream into stereo words.
//   clk        : system clock (>= 8x BCLK)
//   reset      : synchronous active-high reset
//   sclk       : BCLK, asynchronous, sampled as data
//   lrclk      : ADCLRC word select (0 = left, 1 = right), asynchronous
//   sdata      : ADCDAT serial data, MSB first, asynchronous
//   left_chan  : last complete left word of a coherent pair
//   right_chan : last complete right word of a coherent pair
//   valid      : one-clk pulse when left_chan/right_chan update together
//   frame_err  : one-clk pulse when a slot ends before BITSIZE bits arrived
module i2s_rx
  import i2s_rx_pkg::*;
#(
  parameter int unsigned BITSIZE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               lrclk,
  input  logic               sdata,
  output logic [BITSIZE-1:0] left_chan,
  output logic [BITSIZE-1:0] right_chan,
  output logic               valid,
  output logic               frame_err
);

  // Wide enough for a full word plus the delay slot.
  localparam int unsigned CW = $clog2(BITSIZE + I2S_DELAY_BITS + 1);

  logic sclk_rise;
  logic lrclk_s;
  logic sdata_s;

  i2s_edge_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .lrclk     (lrclk),
    .sdata     (sdata),
    .sclk_rise (sclk_rise),
    .lrclk_s   (lrclk_s),
    .sdata_s   (sdata_s)
  );

  state_e             state_q, state_d;
  chan_e              chan_q, chan_d;
  logic               lr_prev_q, lr_prev_d;
  logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [BITSIZE-1:0] shift_q, shift_d;
  logic [BITSIZE-1:0] left_hold_q, left_hold_d;
  logic               left_ok_q, left_ok_d;
  logic [BITSIZE-1:0] left_q, left_d;
  logic [BITSIZE-1:0] right_q, right_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;

  logic [BITSIZE-1:0] word;
  assign word = {shift_q[BITSIZE-2:0], sdata_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SYNC;
      chan_q      <= LEFT;
      lr_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      lr_prev_q   <= lr_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    lr_prev_d   = lr_prev_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    if (sclk_rise) begin
      lr_prev_d = lrclk_s;
      if (lrclk_s != lr_prev_q) begin
        // Word-select change: this bit is the delay slot and carries no data.
        bit_cnt_d = '0;
        chan_d    = chan_e'(lrclk_s);
        shift_d   = '0;
        state_d   = SHIFT;
        if (state_q == SHIFT) ferr_d = 1'b1;
        if (chan_e'(lrclk_s) == LEFT) left_ok_d = 1'b0;
      end else begin
        case (state_q)
          SHIFT: begin
            shift_d   = word;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == CW'(BITSIZE - 1)) begin
              state_d = DONE;
              if (chan_q == LEFT) begin
                left_hold_d = word;
                left_ok_d   = 1'b1;
              end else if (left_ok_q) begin
                left_d  = left_hold_q;
                right_d = word;
                valid_d = 1'b1;
              end
            end
          end
          // SYNC waits for a boundary; DONE ignores trailing slot bits.
          default: ;
        endcase
      end
    end
  end

  assign left_chan  = left_q;
  assign right_chan = right_q;
  assign valid      = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_i2s_rx.sv
`timescale 1ns/1ps
module tb_i2s_rx;

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        lrclk;
  logic        sdata;
  logic [15:0] l16, r16;
  logic [23:0] l24, r24;
  logic        v16, fe16, v24, fe24;

  i2s_rx #(.BITSIZE(16)) dut16 (
    .clk(clk), .reset(reset), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .left_chan(l16), .right_chan(r16), .valid(v16), .frame_err(fe16)
  );

  i2s_rx #(.BITSIZE(24)) dut24 (
    .clk(clk), .reset(reset), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .left_chan(l24), .right_chan(r24), .valid(v24), .frame_err(fe24)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_chk;
  int          n_fail;
  bit          jit;
  bit          rst_s;

  // Slot-level model, one instance per word width (index 0: 16, 1: 24).
  int          mB [2];
  logic        m_lrp [2];
  bit          m_inc [2];
  bit          m_ok [2];
  logic [31:0] m_lhold [2];
  logic [63:0] hold_exp [2];
  int          err_pend [2];
  int          vcnt [2];
  int          ecnt [2];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  // Predict the effect of one whole slot given its channel, payload (data
  // bits MSB-first after the delay bit) and total length in bit clocks.
  function automatic void model_slot(input int i, input logic ch, input logic [31:0] payload,
                                     input int len);
    logic [31:0] w;
    if (ch == m_lrp[i]) return;  // no word-select change: still unsynced, ignored
    m_lrp[i] = ch;
    if (m_inc[i]) err_pend[i]++;
    m_inc[i] = 1'b0;
    if (ch == 1'b0) m_ok[i] = 1'b0;
    if (len - 1 >= mB[i]) begin
      w = payload >> (32 - mB[i]);
      if (ch == 1'b0) begin
        m_lhold[i] = w;
        m_ok[i]    = 1'b1;
      end else if (m_ok[i]) begin
        if (i == 0) q0.push_back({m_lhold[i], w});
        else        q1.push_back({m_lhold[i], w});
      end
    end else begin
      m_inc[i] = 1'b1;
    end
  endfunction

  task automatic cmp(input int i, input logic v, input logic [31:0] l, input logic [31:0] r,
                     input logic fe);
    logic [63:0] e;
    string       tag;
    tag = (i == 0) ? "b16" : "b24";
    if (rst_s) begin
      check({tag, "_rst_left"}, l, 32'h0);
      check({tag, "_rst_right"}, r, 32'h0);
      check({tag, "_rst_valid"}, 32'(v), 32'h0);
      check({tag, "_rst_ferr"}, 32'(fe), 32'h0);
      return;
    end
    if (v) begin
      vcnt[i]++;
      n_chk++;
      if (qsize(i) == 0) begin
        n_fail++;
        $display("FAIL %s_valid: got valid=1 with no pair pending, expected valid=0", tag);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        check({tag, "_pair_left"}, l, e[63:32]);
        check({tag, "_pair_right"}, r, e[31:0]);
        hold_exp[i] = e;
      end
    end else begin
      check({tag, "_hold_left"}, l, hold_exp[i][63:32]);
      check({tag, "_hold_right"}, r, hold_exp[i][31:0]);
    end
    if (fe) begin
      ecnt[i]++;
      n_chk++;
      if (err_pend[i] == 0) begin
        n_fail++;
        $display("FAIL %s_frame_err: got frame_err=1 with none pending, expected 0", tag);
      end else begin
        err_pend[i]--;
      end
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    int j;
    j = jit ? $urandom_range(0, 20) : 5;
    sclk = 1'b0;
    #(j);
    lrclk = lr;
    sdata = d;
    #(41 - j);
    sclk = 1'b1;
    #41;
  endtask

  task automatic send_slot(input logic ch, input logic [31:0] payload, input int len);
    model_slot(0, ch, payload, len);
    model_slot(1, ch, payload, len);
    send_bit(ch, 1'($urandom_range(0, 1)));
    for (int k = 0; k < len - 1; k++) send_bit(ch, payload[31-k]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    idle(4);
    reset = 1'b1;
    idle(1);
    check("drain_pairs_b16", 32'(q0.size()), 32'h0);
    check("drain_pairs_b24", 32'(q1.size()), 32'h0);
    check("drain_err_b16", 32'(err_pend[0]), 32'h0);
    check("drain_err_b24", 32'(err_pend[1]), 32'h0);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_lrp[i]    = 1'b0;
      m_inc[i]    = 1'b0;
      m_ok[i]     = 1'b0;
      m_lhold[i]  = '0;
      hold_exp[i] = '0;
      err_pend[i] = 0;
    end
    idle(3);
    check("in_reset_left16", 32'(l16), 32'h0);
    check("in_reset_right16", 32'(r16), 32'h0);
    check("in_reset_left24", 32'(l24), 32'h0);
    check("in_reset_valid16", 32'(v16), 32'h0);
    reset = 1'b0;
    idle(4);
  endtask

  int vb, eb, vb24;

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    lrclk = 1'b0;
    sdata = 1'b0;
    jit   = 1'b0;
    n_chk = 0;
    n_fail = 0;
    rst_s = 1'b1;
    mB[0] = 16;
    mB[1] = 24;
    for (int i = 0; i < 2; i++) begin
      m_lrp[i] = 1'b0; m_inc[i] = 1'b0; m_ok[i] = 1'b0; m_lhold[i] = '0;
      hold_exp[i] = '0; err_pend[i] = 0; vcnt[i] = 0; ecnt[i] = 0;
    end

    fork
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected test completion");
        $fatal(1, "timeout");
      end
      forever begin
        @(posedge clk);
        rst_s = reset;
        @(negedge clk);
        cmp(0, v16, 32'(l16), 32'(r16), fe16);
        cmp(1, v24, 32'(l24), 32'(r24), fe24);
      end
    join_none

    do_reset();

    // 1: basic frame after sync (first left slot has no word-select change)
    vb = vcnt[0]; eb = ecnt[0];
    send_slot(1'b0, {16'h1234, 16'($urandom)}, 32);
    send_slot(1'b1, {16'hABCD, 16'($urandom)}, 32);
    send_slot(1'b0, {16'h1234, 16'($urandom)}, 32);
    send_slot(1'b1, {16'hABCD, 16'($urandom)}, 32);
    idle(8);
    check("t1_left", 32'(l16), 32'h1234);
    check("t1_right", 32'(r16), 32'hABCD);
    check("t1_valid_count", 32'(vcnt[0] - vb), 32'd1);
    check("t1_ferr_count", 32'(ecnt[0] - eb), 32'd0);

    // 2: stream starts on the right slot
    do_reset();
    vb = vcnt[0];
    send_slot(1'b1, $urandom, 32);
    send_slot(1'b0, {16'h0001, 16'($urandom)}, 32);
    send_slot(1'b1, {16'h8000, 16'($urandom)}, 32);
    check("t2_left_a", 32'(l16), 32'h0001);
    check("t2_right_a", 32'(r16), 32'h8000);
    send_slot(1'b0, {16'h7FFF, 16'($urandom)}, 32);
    send_slot(1'b1, {16'hFFFF, 16'($urandom)}, 32);
    idle(8);
    check("t2_left_b", 32'(l16), 32'h7FFF);
    check("t2_right_b", 32'(r16), 32'hFFFF);
    check("t2_valid_count", 32'(vcnt[0] - vb), 32'd2);

    // 3: truncated left slot
    vb = vcnt[0]; eb = ecnt[0];
    send_slot(1'b0, {16'hBEEF, 16'($urandom)}, 10);
    send_slot(1'b1, {16'h5555, 16'($urandom)}, 32);
    check("t3_ferr_count", 32'(ecnt[0] - eb), 32'd1);
    check("t3_no_valid", 32'(vcnt[0] - vb), 32'd0);
    send_slot(1'b0, {16'h1357, 16'($urandom)}, 32);
    send_slot(1'b1, {16'h5555, 16'($urandom)}, 32);
    idle(8);
    check("t3_left", 32'(l16), 32'h1357);
    check("t3_right", 32'(r16), 32'h5555);
    check("t3_valid_count", 32'(vcnt[0] - vb), 32'd1);
    check("t3_ferr_total", 32'(ecnt[0] - eb), 32'd1);

    // 4: reset in the middle of a left word
    send_slot(1'b0, {16'hC3C3, 16'($urandom)}, 9);
    do_reset();
    vb = vcnt[0]; eb = ecnt[0];
    send_slot(1'b0, $urandom, 32);
    send_slot(1'b1, $urandom, 32);
    send_slot(1'b0, {16'h00FF, 16'($urandom)}, 32);
    send_slot(1'b1, {16'hFF00, 16'($urandom)}, 32);
    idle(8);
    check("t4_left", 32'(l16), 32'h00FF);
    check("t4_right", 32'(r16), 32'hFF00);
    check("t4_valid_count", 32'(vcnt[0] - vb), 32'd1);
    check("t4_ferr_count", 32'(ecnt[0] - eb), 32'd0);

    // 5: 24-bit words with 8 trailing garbage bits
    vb24 = vcnt[1];
    send_slot(1'b0, {24'h800001, 8'($urandom)}, 32);
    send_slot(1'b1, {24'h7FFFFE, 8'($urandom)}, 32);
    idle(8);
    check("t5_left24", 32'(l24), 32'h800001);
    check("t5_right24", 32'(r24), 32'h7FFFFE);
    check("t5_valid24_count", 32'(vcnt[1] - vb24), 32'd1);
    check("t5_left16_msbs", 32'(l16), 32'h8000);
    check("t5_right16_msbs", 32'(r16), 32'h7FFF);

    // 6: random frames with data-line jitter, short slots
    jit = 1'b1;
    vb = vcnt[0]; eb = ecnt[0];
    for (int f = 0; f < 150; f++) begin
      send_slot(1'b0, $urandom, $urandom_range(17, 20));
      send_slot(1'b1, $urandom, $urandom_range(17, 20));
    end
    jit = 1'b0;
    idle(20);
    check("t6_valid_count", 32'(vcnt[0] - vb), 32'd150);
    check("t6_ferr16_count", 32'(ecnt[0] - eb), 32'd0);

    check("end_pairs_b16", 32'(q0.size()), 32'h0);
    check("end_pairs_b24", 32'(q1.size()), 32'h0);
    check("end_err_b16", 32'(err_pend[0]), 32'h0);
    check("end_err_b24", 32'(err_pend[1]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
